// File: rtl/gpio_shift_pkg.sv
// ============================================================================
// Module   : gpio_shift_pkg
// Purpose  : Shared state encoding and limits for the gpio_shift_src source.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package gpio_shift_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    EMPTY  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gpio_shift_src_sync.sv
// ============================================================================
// Module   : gpio_sync
// Purpose  : N-stage input synchronizer with reset value and rising-edge flag.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpio_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/gpio_shift_src.sv
// ============================================================================
// Module   : gpio_shift_src
// Purpose  : 74HC165-style parallel-in/serial-out source answering shiftIn().
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpio_shift_src
  import gpio_shift_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic [WIDTH-1:0]           load_data_i,
  input  logic                       load_i,
  input  logic                       msb_first_i,
  input  logic                       ser_i,
  input  logic                       sclk_i,
  input  logic                       latch_n_i,
  output logic                       sdata_o,
  output logic                       busy_o,
  output logic [$clog2(WIDTH+1)-1:0] bits_left_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  localparam int BW     = $clog2(WIDTH+1);
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_stage, r_shift, w_shifted;
  logic             r_order, r_sdata, r_done, r_ovr;
  logic [BW-1:0]    r_left;
  logic             w_sclk_rise, w_unused_sclk_lvl;
  logic             w_latch_n, w_latch_rise, w_latch_act;

  gpio_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sclk_i),
    .o_sync  (w_unused_sclk_lvl),
    .o_rise  (w_sclk_rise)
  );

  gpio_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (latch_n_i),
    .o_sync  (w_latch_n),
    .o_rise  (w_latch_rise)
  );

  assign w_latch_act = ~w_latch_n;

  function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic msb);
    return msb ? v[WIDTH-1] : v[0];
  endfunction

  // Output bit sits at the MSB or LSB end; the fill bit enters at the other end.
  always_comb begin
    w_shifted = r_order ? ((r_shift << 1) | WIDTH'(ser_i))
                        : ((r_shift >> 1) | (WIDTH'(ser_i) << (WIDTH-1)));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = IDLE;
    end else if (w_latch_act) begin
      w_state_nxt = LOADED;
    end else begin
      case (r_state)
        LOADED:  if (w_latch_rise) w_state_nxt = SHIFT;
        SHIFT:   if (w_sclk_rise && (r_left == BW'(1))) w_state_nxt = EMPTY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch has priority over a coincident clock edge, so it is tested first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_shift <= '0;
      r_order <= 1'b0;
      r_sdata <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_left  <= '0;
    end else begin
      r_done <= 1'b0;
      if (load_i) r_stage <= load_data_i;
      if (!enable_i) begin
        r_sdata <= 1'b0;
        r_left  <= '0;
      end else if (w_latch_act) begin
        r_shift <= r_stage;
        r_order <= msb_first_i;
        r_left  <= BW'(WIDTH);
        r_ovr   <= 1'b0;
        r_sdata <= first_bit(r_stage, msb_first_i);
      end else if (w_sclk_rise && (r_state == SHIFT || r_state == EMPTY)) begin
        r_shift <= w_shifted;
        r_sdata <= first_bit(w_shifted, r_order);
        if (r_state == SHIFT) begin
          r_left <= r_left - 1'b1;
          r_done <= (r_left == BW'(1));
        end else begin
          r_ovr  <= 1'b1;
        end
      end
    end
  end

  assign sdata_o     = r_sdata;
  assign busy_o      = (r_state == SHIFT);
  assign bits_left_o = r_left;
  assign done_o      = r_done;
  assign overrun_o   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_gpio_shift_src.sv
// ============================================================================
// Module   : tb_gpio_shift_src
// Purpose  : Scoreboard bench for gpio_shift_src against a bit-queue model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gpio_shift_src;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b1;
  logic [7:0] load_data_i = 8'h00;
  logic       load_i = 1'b0;
  logic       msb_first_i = 1'b1;
  logic       ser_i = 1'b0;
  logic       sclk_i = 1'b0;
  logic       latch_n_i = 1'b1;

  logic       sdata_o, busy_o, done_o, overrun_o;
  logic [3:0] bits_left_o;
  logic       d3_sdata, d3_busy, d3_done, d3_ovr;
  logic [3:0] d3_left;

  always #5 clk = ~clk;

  gpio_shift_src #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .load_data_i(load_data_i),
    .load_i(load_i), .msb_first_i(msb_first_i), .ser_i(ser_i), .sclk_i(sclk_i),
    .latch_n_i(latch_n_i), .sdata_o(sdata_o), .busy_o(busy_o),
    .bits_left_o(bits_left_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  gpio_shift_src #(.WIDTH(8), .SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .load_data_i(load_data_i),
    .load_i(load_i), .msb_first_i(msb_first_i), .ser_i(ser_i), .sclk_i(sclk_i),
    .latch_n_i(latch_n_i), .sdata_o(d3_sdata), .busy_o(d3_busy),
    .bits_left_o(d3_left), .done_o(d3_done), .overrun_o(d3_ovr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       sd;
    logic [3:0] left;
    logic       ovr;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  int         done_cnt = 0;
  int         d3_done_cnt = 0;
  logic [7:0] mon_bits = 8'h00;

  // Reference model: pending output bits as a queue, consumed one per edge.
  bit         m_q[$];
  int         m_left   = 0;
  bit         m_ovr    = 0;
  bit         m_active = 0;
  int         m_done   = 0;
  logic [7:0] m_stage  = 8'h00;

  function automatic logic m_sd();
    return m_active ? m_q[0] : 1'b0;
  endfunction

  function automatic logic m_busy();
    return m_active && (m_left > 0);
  endfunction

  task automatic m_latch(input bit msb);
    m_q.delete();
    for (int i = 0; i < 8; i++) m_q.push_back(msb ? m_stage[7-i] : m_stage[i]);
    m_left   = 8;
    m_ovr    = 0;
    m_active = 1;
  endtask

  task automatic m_edge();
    if (!m_active) return;
    void'(m_q.pop_front());
    m_q.push_back(ser_i);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done++;
    end else begin
      m_ovr = 1;
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_now(input string nm);
    cmp({nm, "_sdata"}, 32'(sdata_o), 32'(m_sd()));
    cmp({nm, "_bits_left"}, 32'(bits_left_o), 32'(m_left));
    cmp({nm, "_overrun"}, 32'(overrun_o), 32'(m_ovr));
    cmp({nm, "_busy"}, 32'(busy_o), 32'(m_busy()));
    cmp({nm, "_done_count"}, 32'(done_cnt), 32'(m_done));
  endtask

  function automatic void push_exp();
    exp_q.push_back('{sd: m_sd(), left: 4'(m_left), ovr: m_ovr, busy: m_busy()});
  endfunction

  // Monitor: the consumer reads sdata at each sclk rise, as shiftIn() does.
  always @(posedge sclk_i) begin
    exp_t e;
    mon_bits = {mon_bits[6:0], sdata_o};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sclk_sample: got sclk edge with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if ({sdata_o, bits_left_o, overrun_o, busy_o} !== {e.sd, e.left, e.ovr, e.busy}) begin
        n_fail++;
        $display("FAIL sclk_sample: got sd=%b left=%0d ovr=%b busy=%b expected sd=%b left=%0d ovr=%b busy=%b",
                 sdata_o, bits_left_o, overrun_o, busy_o, e.sd, e.left, e.ovr, e.busy);
      end
    end
  end

  always @(negedge clk) begin
    if (done_o === 1'b1)  done_cnt++;
    if (d3_done === 1'b1) d3_done_cnt++;
  end

  task automatic do_load(input logic [7:0] v);
    load_data_i = v;
    load_i      = 1'b1;
    @(negedge clk);
    load_i      = 1'b0;
    m_stage     = v;
  endtask

  task automatic do_latch(input bit msb);
    msb_first_i = msb;
    latch_n_i   = 1'b0;
    repeat (4) @(negedge clk);
    m_latch(msb);
    cmp("latch_bits_left", 32'(bits_left_o), 32'd8);
    cmp("latch_first_bit", 32'(sdata_o), 32'(m_q[0]));
    cmp("latch_busy", 32'(busy_o), 32'd0);
    latch_n_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    push_exp();
    sclk_i = 1'b1;
    repeat (hi) @(negedge clk);
    sclk_i = 1'b0;
    m_edge();
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(10, 10);
  endtask

  initial begin
    logic prev2, prev3;
    int   lat2, lat3;

    repeat (3) @(negedge clk);
    check_now("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // MSB-first pattern
    ser_i = 1'b0;
    do_load(8'hC9);
    do_latch(1'b1);
    pulses(8);
    cmp("pattern_seq", 32'(mon_bits), 32'hC9);
    check_now("pattern_end");

    // LSB-first with fill bit 1 and overrun
    ser_i = 1'b1;
    do_load(8'hC9);
    do_latch(1'b0);
    pulses(8);
    cmp("lsb_seq", 32'(mon_bits), 32'h93);
    pulse(10, 10);
    cmp("lsb_overrun_flag", 32'(overrun_o), 32'd1);
    cmp("lsb_fill_bit", 32'(sdata_o), 32'd1);
    check_now("lsb_overrun");

    // Relatch mid-transfer
    ser_i = 1'b0;
    do_load(8'hA5);
    do_latch(1'b1);
    pulses(3);
    do_load(8'h3C);
    do_latch(1'b1);
    check_now("relatch_abandon");
    pulses(8);
    cmp("relatch_seq", 32'(mon_bits), 32'h3C);
    check_now("relatch_end");

    // Latency through 2- and 3-stage synchronizers
    do_load(8'hC9);
    do_latch(1'b0);
    push_exp();
    prev2 = sdata_o;
    prev3 = d3_sdata;
    lat2 = 0;
    lat3 = 0;
    sclk_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (lat2 == 0 && sdata_o !== prev2) lat2 = c;
      if (lat3 == 0 && d3_sdata !== prev3) lat3 = c;
    end
    cmp("latency_sync2", 32'(lat2), 32'd3);
    cmp("latency_sync3", 32'(lat3), 32'd4);
    cmp("sync3_bits_left", 32'(d3_left), 32'd7);
    cmp("sync3_busy", 32'(d3_busy), 32'd1);
    cmp("sync3_overrun", 32'(d3_ovr), 32'd0);
    @(negedge clk);
    sclk_i = 1'b0;
    m_edge();
    repeat (10) @(negedge clk);
    check_now("latency_end");

    // Enable abort
    do_load(8'h5A);
    do_latch(1'b1);
    pulses(2);
    enable_i = 1'b0;
    m_active = 0;
    m_left   = 0;
    repeat (3) @(negedge clk);
    check_now("enable_abort");
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    pulse(10, 10);
    check_now("idle_ignores_sclk");

    // Asynchronous reset mid-shift
    do_load(8'h96);
    do_latch(1'b1);
    pulses(3);
    #3 rst_n = 1'b0;
    #1;
    m_q.delete();
    m_active = 0;
    m_left   = 0;
    m_ovr    = 0;
    m_stage  = 8'h00;
    cmp("reset_async_outputs", 32'({sdata_o, busy_o, bits_left_o, done_o, overrun_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_now("after_reset");
    do_latch(1'b1);
    cmp("staging_cleared", 32'(sdata_o), 32'd0);

    // Latch and sclk edge synchronized in the same cycle
    do_load(8'hC9);
    do_latch(1'b1);
    pulses(3);
    push_exp();
    sclk_i = 1'b1;
    do_latch(1'b1);
    sclk_i = 1'b0;
    repeat (10) @(negedge clk);
    check_now("latch_priority");
    pulses(8);
    cmp("priority_seq", 32'(mon_bits), 32'hC9);
    check_now("priority_end");

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      int n;
      bit msb;
      ser_i = 1'($urandom);
      msb   = 1'($urandom);
      n     = $urandom_range(0, 11);
      do_load(8'($urandom));
      do_latch(msb);
      for (int k = 0; k < n; k++) pulse($urandom_range(3, 8), $urandom_range(3, 8));
      check_now("random");
    end

    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    cmp("sync3_done_count", 32'(d3_done_cnt), 32'(m_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
